// File: rtl/apb_master_bridge_if.sv
// Signal bundle for the APB master bridge: local command port, response port and APB bus.
// Handshake rule for cmd and rsp: a beat transfers on a pclk edge where valid & ready are both 1.
// The source holds valid and its payload stable until that edge. Ready may depend on state but never on valid.
interface apb_master_bridge_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB requester: one command in, one SETUP/ACCESS transfer out, one response back.
// The ACCESS wait is bounded by a timeout counter (TIMEOUT_CYC = 0 disables it).
module apb_master_bridge #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                pclk,
  input  logic                preset_n,
  apb_master_bridge_if.master bus,
  output logic [1:0]          state_dbg
);
  localparam int CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  tcnt, tcnt_next, tcnt_inc;
  logic              timeout_hit;
  logic              psel_next, penable_next, pwrite_next;
  logic [ADDR_W-1:0] paddr_next;
  logic [DATA_W-1:0] pwdata_next;
  logic              rsp_valid_next, rsp_err_next, rsp_timeout_next;
  logic [DATA_W-1:0] rsp_rdata_next;

  assign bus.cmd_ready = preset_n && (state == IDLE);
  assign state_dbg     = state;
  assign tcnt_inc      = tcnt + CNT_W'(1);
  // The edge that would bring the low-pready count to TIMEOUT_CYC is the abort edge.
  assign timeout_hit   = (TIMEOUT_CYC != 0) && (tcnt_inc == CNT_W'(TIMEOUT_CYC));

  always_comb begin
    state_next       = state;
    tcnt_next        = tcnt;
    psel_next        = bus.psel;
    penable_next     = bus.penable;
    pwrite_next      = bus.pwrite;
    paddr_next       = bus.paddr;
    pwdata_next      = bus.pwdata;
    rsp_valid_next   = bus.rsp_valid;
    rsp_rdata_next   = bus.rsp_rdata;
    rsp_err_next     = bus.rsp_err;
    rsp_timeout_next = bus.rsp_timeout;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_next   = SETUP;
          pwrite_next  = bus.cmd_write;
          paddr_next   = bus.cmd_addr;
          pwdata_next  = bus.cmd_wdata;
          psel_next    = 1'b1;
          penable_next = 1'b0;
          tcnt_next    = '0;
        end
      end
      SETUP: begin
        state_next   = ACCESS;
        penable_next = 1'b1;
      end
      ACCESS: begin
        if (bus.pready) begin
          state_next       = RESP;
          psel_next        = 1'b0;
          penable_next     = 1'b0;
          rsp_valid_next   = 1'b1;
          rsp_rdata_next   = bus.pwrite ? '0 : bus.prdata;
          rsp_err_next     = bus.pslverr;
          rsp_timeout_next = 1'b0;
        end else if (timeout_hit) begin
          state_next       = RESP;
          psel_next        = 1'b0;
          penable_next     = 1'b0;
          rsp_valid_next   = 1'b1;
          rsp_rdata_next   = '0;
          rsp_err_next     = 1'b1;
          rsp_timeout_next = 1'b1;
        end else if (TIMEOUT_CYC != 0) begin
          tcnt_next = tcnt_inc;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state           <= IDLE;
      tcnt            <= '0;
      bus.psel        <= 1'b0;
      bus.penable     <= 1'b0;
      bus.pwrite      <= 1'b0;
      bus.paddr       <= '0;
      bus.pwdata      <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      state           <= state_next;
      tcnt            <= tcnt_next;
      bus.psel        <= psel_next;
      bus.penable     <= penable_next;
      bus.pwrite      <= pwrite_next;
      bus.paddr       <= paddr_next;
      bus.pwdata      <= pwdata_next;
      bus.rsp_valid   <= rsp_valid_next;
      bus.rsp_rdata   <= rsp_rdata_next;
      bus.rsp_err     <= rsp_err_next;
      bus.rsp_timeout <= rsp_timeout_next;
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: scripted APB responder plus a response scoreboard.
module tb_apb_master_bridge;
  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 8;
  localparam int TIMEOUT_CYC = 16;
  localparam int W           = DATA_W + 2;

  logic       pclk = 1'b0;
  logic       preset_n = 1'b0;
  logic [1:0] state_dbg;
  int         checks = 0;
  int         errors = 0;
  logic [W-1:0] exp_q[$];

  apb_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_master_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .pclk      (pclk),
    .preset_n  (preset_n),
    .bus       (bus.master),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive_idle();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
  endtask

  // One full transfer: drive command, play responder, check APB pins, hold rsp, score response.
  task automatic run_xfer(input logic wr, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rd,
                          input logic slv_err, input int stalls, input int hold,
                          input string tag);
    logic         timed_out;
    int           edges, pen_cycles, waited, exp_edges, exp_pen;
    logic [W-1:0] exp, got;
    timed_out = (TIMEOUT_CYC != 0) && (stalls >= TIMEOUT_CYC);
    exp_edges = timed_out ? 1 + TIMEOUT_CYC : 2 + stalls;
    exp_pen   = timed_out ? TIMEOUT_CYC : stalls + 1;
    waited = 0;
    while (bus.cmd_ready !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s cmd_ready_wait: got %b want 1", tag, bus.cmd_ready);
    end
    if (timed_out) exp = {1'b1, 1'b1, {DATA_W{1'b0}}};
    else           exp = {1'b0, slv_err, (wr ? {DATA_W{1'b0}} : rd)};
    exp_q.push_back(exp);

    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b1;
    tick();
    // scramble the command port so a design that re-reads it is caught
    bus.cmd_valid = 1'b0;
    bus.cmd_write = ~wr;
    bus.cmd_addr  = ~addr;
    bus.cmd_wdata = ~wdata;

    checks++;
    if (bus.psel !== 1'b1 || bus.penable !== 1'b0 || bus.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s setup_phase: got psel=%b penable=%b cmd_ready=%b want 1 0 0",
               tag, bus.psel, bus.penable, bus.cmd_ready);
    end
    checks++;
    if (bus.paddr !== addr || bus.pwrite !== wr || (wr && bus.pwdata !== wdata)) begin
      errors++;
      $display("FAIL %s setup_fields: got addr=%h wr=%b wdata=%h want %h %b %h",
               tag, bus.paddr, bus.pwrite, bus.pwdata, addr, wr, wdata);
    end

    edges = 0;
    pen_cycles = 0;
    while (bus.rsp_valid !== 1'b1 && edges < 40) begin
      tick();
      edges++;
      if (bus.penable === 1'b1) begin
        pen_cycles++;
        bus.pready  = (pen_cycles > stalls);
        bus.pslverr = bus.pready ? slv_err : 1'b1;
        bus.prdata  = bus.pready ? rd : DATA_W'($urandom);
        checks++;
        if (bus.psel !== 1'b1 || bus.paddr !== addr || bus.pwrite !== wr ||
            (wr && bus.pwdata !== wdata)) begin
          errors++;
          $display("FAIL %s access_stable: got psel=%b addr=%h wr=%b wdata=%h want 1 %h %b %h",
                   tag, bus.psel, bus.paddr, bus.pwrite, bus.pwdata, addr, wr, wdata);
        end
      end else begin
        bus.pready = 1'b0;
      end
    end
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;

    checks++;
    if (edges != exp_edges || bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: got %0d edges rsp_valid=%b want %0d edges", tag, edges,
               bus.rsp_valid, exp_edges);
    end
    checks++;
    if (pen_cycles != exp_pen) begin
      errors++;
      $display("FAIL %s penable_cycles: got %0d want %0d", tag, pen_cycles, exp_pen);
    end
    checks++;
    if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.cmd_ready !== 1'b0 ||
        bus.paddr !== addr) begin
      errors++;
      $display("FAIL %s resp_phase: got psel=%b penable=%b cmd_ready=%b addr=%h want 0 0 0 %h",
               tag, bus.psel, bus.penable, bus.cmd_ready, bus.paddr, addr);
    end

    // back-pressure: a waiting command must not start a transfer
    if (hold > 0) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 8'hEE;
      bus.cmd_wdata = 8'h11;
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      got = {bus.rsp_timeout, bus.rsp_err, bus.rsp_rdata};
      checks++;
      if (bus.rsp_valid !== 1'b1 || got !== exp || bus.cmd_ready !== 1'b0 ||
          bus.psel !== 1'b0) begin
        errors++;
        $display("FAIL %s rsp_hold[%0d]: got valid=%b rsp=%h cmd_ready=%b psel=%b want 1 %h 0 0",
                 tag, i, bus.rsp_valid, got, bus.cmd_ready, bus.psel, exp);
      end
    end
    bus.cmd_valid = 1'b0;

    // scoreboard: pop expected at the response handshake
    got = {bus.rsp_timeout, bus.rsp_err, bus.rsp_rdata};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard_empty: got rsp=%h want queued entry", tag, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s rsp_data: got {to,err,rdata}=%h want %h", tag, got, exp);
      end
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.psel !== 1'b0) begin
      errors++;
      $display("FAIL %s rsp_done: got valid=%b cmd_ready=%b psel=%b want 0 1 0",
               tag, bus.rsp_valid, bus.cmd_ready, bus.psel);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    preset_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.rsp_valid !== 1'b0 ||
        bus.rsp_err !== 1'b0 || bus.rsp_timeout !== 1'b0 || bus.rsp_rdata !== '0 ||
        bus.paddr !== '0 || bus.pwdata !== '0 || bus.pwrite !== 1'b0 ||
        bus.cmd_ready !== 1'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: got psel=%b pen=%b rv=%b cmd_ready=%b state=%0d want all 0",
               bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready, state_dbg);
    end
    preset_n = 1'b1;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_cmd_ready: got %b want 1", bus.cmd_ready);
    end
    tick();
  endtask

  task automatic test_read_basic();
    run_xfer(1'b0, 8'h03, 8'h00, 8'h48, 1'b0, 0, 0, "read_basic");
  endtask

  task automatic test_write_stall();
    run_xfer(1'b1, 8'h05, 8'hA5, 8'h99, 1'b0, 3, 0, "write_stall");
  endtask

  task automatic test_slverr();
    run_xfer(1'b0, 8'h20, 8'h00, 8'h5A, 1'b1, 0, 0, "read_slverr");
    run_xfer(1'b1, 8'h21, 8'h3C, 8'h00, 1'b1, 2, 0, "write_slverr");
  endtask

  task automatic test_timeout();
    run_xfer(1'b0, 8'h33, 8'h00, 8'h77, 1'b0, 100, 0, "timeout");
    run_xfer(1'b0, 8'h34, 8'h00, 8'h6B, 1'b0, TIMEOUT_CYC - 1, 0, "timeout_edge_ready");
  endtask

  task automatic test_rsp_backpressure();
    run_xfer(1'b0, 8'h44, 8'h00, 8'hC3, 1'b0, 1, 5, "backpressure");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      run_xfer(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 255)),
               DATA_W'($urandom_range(0, 255)), DATA_W'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 2),
               $sformatf("b2b_%0d", i));
    end
  endtask

  task automatic test_reset_mid();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h55;
    bus.pready    = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.penable !== 1'b1 || bus.psel !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_in_access: got psel=%b penable=%b want 1 1", bus.psel, bus.penable);
    end
    preset_n = 1'b0;
    tick();
    checks++;
    if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.rsp_valid !== 1'b0 ||
        bus.cmd_ready !== 1'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_abort: got psel=%b pen=%b rv=%b cmd_ready=%b state=%0d want 0 0 0 0 0",
               bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready, state_dbg);
    end
    preset_n = 1'b1;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_cmd_ready: got %b want 1", bus.cmd_ready);
    end
    repeat (3) begin
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.psel !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_no_rsp: got rv=%b psel=%b want 0 0", bus.rsp_valid, bus.psel);
      end
    end
    run_xfer(1'b1, 8'h56, 8'h0F, 8'h00, 1'b0, 0, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_stall();
    test_slverr();
    test_timeout();
    test_rsp_backpressure();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
